// File: rtl/dataint_crc_frame_pkg.sv
// Shared FSM state encoding and small helpers for the CRC frame controller.
package dataint_crc_frame_pkg;

  localparam logic [2:0] ST_IDLE_ENC   = 3'd0;
  localparam logic [2:0] ST_START_ENC  = 3'd1;
  localparam logic [2:0] ST_DATA_ENC   = 3'd2;
  localparam logic [2:0] ST_DRAIN_ENC  = 3'd3;
  localparam logic [2:0] ST_CAPT_ENC   = 3'd4;
  localparam logic [2:0] ST_RESULT_ENC = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE   = ST_IDLE_ENC,
    ST_START  = ST_START_ENC,
    ST_DATA   = ST_DATA_ENC,
    ST_DRAIN  = ST_DRAIN_ENC,
    ST_CAPT   = ST_CAPT_ENC,
    ST_RESULT = ST_RESULT_ENC
  } state_e;

  // Unsigned add that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/dataint_crc_frame_sel_dec.sv
// Turns a beat's byte count into the engine's one-hot cascade select,
// clamping oversized counts to a full beat and flagging them.
module dataint_crc_frame_sel_dec #(
  parameter int CHUNKS = 8,
  localparam int BW = $clog2(CHUNKS) + 1
) (
  input  logic [BW-1:0]     i_bytes,
  output logic [CHUNKS-1:0] o_sel,
  output logic [BW-1:0]     o_bytes_eff,
  output logic              o_err
);

  always_comb begin
    o_err       = 1'b0;
    o_bytes_eff = i_bytes;
    if (i_bytes > BW'(CHUNKS)) begin
      o_err       = 1'b1;
      o_bytes_eff = BW'(CHUNKS);
    end
    o_sel = '0;
    for (int k = 0; k < CHUNKS; k++) begin
      if (o_bytes_eff == BW'(k + 1)) o_sel[k] = 1'b1;
    end
  end

endmodule

// File: rtl/dataint_crc_frame_ctrl.sv
// Frame sequencer that feeds a cascaded CRC engine and returns one CRC per frame.
// Optional byte counter enabled by macro DATAINT_CRC_FRAME_CTRL_BYTECNT_EN.
module dataint_crc_frame_ctrl
  import dataint_crc_frame_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CHUNKS     = DATA_WIDTH / 8,
  parameter int CRC_WIDTH  = 64
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [DATA_WIDTH-1:0]    i_data,
  input  logic [$clog2(CHUNKS):0]  i_bytes,
  input  logic                     i_last,
  input  logic                     i_abort,
  output logic                     o_load_crc_start,
  output logic                     o_load_from_cascade,
  output logic [CHUNKS-1:0]        o_cascade_sel,
  output logic [DATA_WIDTH-1:0]    o_data,
  input  logic [CRC_WIDTH-1:0]     i_crc,
  output logic                     o_crc_valid,
  input  logic                     i_crc_ready,
  output logic [CRC_WIDTH-1:0]     o_crc,
  output logic                     o_err,
  output logic [31:0]              o_byte_count
);

  localparam int BW = $clog2(CHUNKS) + 1;

  state_e                 state_q;
  logic                   captWait_q;
  logic [CRC_WIDTH-1:0]   crc_q;
  logic                   crcValid_q;
  logic                   err_q;

  logic [CHUNKS-1:0]      decSel;
  logic [BW-1:0]          bytesEff;
  logic                   decErr;
  logic                   beatAcc;
  logic                   beatTake;

  dataint_crc_frame_sel_dec #(
    .CHUNKS(CHUNKS)
  ) u_sel_dec (
    .i_bytes     (i_bytes),
    .o_sel       (decSel),
    .o_bytes_eff (bytesEff),
    .o_err       (decErr)
  );

  // An abort on the same cycle as a beat discards that beat entirely.
  assign beatAcc  = i_valid && (state_q == ST_DATA);
  assign beatTake = beatAcc && !i_abort;

  assign o_ready             = (state_q == ST_DATA);
  assign o_load_crc_start    = (state_q == ST_START);
  assign o_load_from_cascade = beatTake && (bytesEff != '0);
  assign o_cascade_sel       = beatTake ? decSel : '0;
  assign o_data              = i_data;
  assign o_crc               = crc_q;
  assign o_crc_valid         = crcValid_q;
  assign o_err               = err_q;

  // CAPT lasts two cycles so the engine's registered CRC has a full cycle to settle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      captWait_q <= 1'b0;
      crc_q      <= '0;
      crcValid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_valid) state_q <= ST_START;
        end
        ST_START: begin
          err_q   <= 1'b0;
          state_q <= i_abort ? ST_IDLE : ST_DATA;
        end
        ST_DATA: begin
          if (i_abort) begin
            state_q <= ST_IDLE;
          end else if (beatAcc) begin
            if (decErr) err_q <= 1'b1;
            if (i_last) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          captWait_q <= 1'b1;
          state_q    <= i_abort ? ST_IDLE : ST_CAPT;
        end
        ST_CAPT: begin
          if (i_abort) begin
            captWait_q <= 1'b0;
            state_q    <= ST_IDLE;
          end else if (captWait_q) begin
            captWait_q <= 1'b0;
          end else begin
            crc_q      <= i_crc;
            crcValid_q <= 1'b1;
            state_q    <= ST_RESULT;
          end
        end
        ST_RESULT: begin
          if (i_crc_ready) begin
            crcValid_q <= 1'b0;
            state_q    <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef DATAINT_CRC_FRAME_CTRL_BYTECNT_EN
  logic [31:0] byteCnt_q;
  logic [31:0] byteCnt_d;

  // Only DATA-state beats count, which freezes the total from DRAIN onwards.
  always_comb begin
    byteCnt_d = byteCnt_q;
    if (state_q == ST_START) begin
      byteCnt_d = '0;
    end else if (beatTake) begin
      byteCnt_d = sat_add32(byteCnt_q, 32'(bytesEff));
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) byteCnt_q <= '0;
    else          byteCnt_q <= byteCnt_d;
  end

  assign o_byte_count = byteCnt_q;
`else
  assign o_byte_count = '0;
`endif

endmodule

// File: tb/tb_dataint_crc_frame_ctrl.sv
// Directed bench for dataint_crc_frame_ctrl with a CRC-32 (reflected) engine model
// and a result scoreboard.
module tb_dataint_crc_frame_ctrl;

  localparam logic [31:0] CRC_CHECK = 32'hCBF43926;
  localparam logic [63:0] D8 = 64'h3837363534333231;
  localparam logic [63:0] D9 = 64'h0000000000000039;
`ifdef DATAINT_CRC_FRAME_CTRL_BYTECNT_EN
  localparam logic [31:0] CNT9 = 32'd9;
`else
  localparam logic [31:0] CNT9 = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        validIn = 1'b0;
  logic [63:0] dataIn = '0;
  logic [3:0]  bytesIn = '0;
  logic        lastIn = 1'b0;
  logic        abortIn = 1'b0;
  logic        crcReadyIn = 1'b1;

  logic        readyOut;
  logic        loadStart;
  logic        loadCascade;
  logic [7:0]  cascadeSel;
  logic [63:0] dataOut;
  logic [31:0] engCrc;
  logic        crcValid;
  logic [31:0] crcOut;
  logic        errOut;
  logic [31:0] byteCount;

  typedef struct {
    logic [31:0] crc;
    logic [31:0] cnt;
    time         riseTime;
  } exp_t;

  exp_t expQ[$];
  exp_t monE;
  int   checks = 0;
  int   failures = 0;
  logic prevValid = 1'b0;
  logic [31:0] engQ = 32'hFFFFFFFF;

  always #5 clk = ~clk;

  dataint_crc_frame_ctrl #(
    .DATA_WIDTH(64),
    .CHUNKS(8),
    .CRC_WIDTH(32)
  ) dut (
    .i_clk               (clk),
    .i_rst_n             (rstN),
    .i_valid             (validIn),
    .o_ready             (readyOut),
    .i_data              (dataIn),
    .i_bytes             (bytesIn),
    .i_last              (lastIn),
    .i_abort             (abortIn),
    .o_load_crc_start    (loadStart),
    .o_load_from_cascade (loadCascade),
    .o_cascade_sel       (cascadeSel),
    .o_data              (dataOut),
    .i_crc               (engCrc),
    .o_crc_valid         (crcValid),
    .i_crc_ready         (crcReadyIn),
    .o_crc               (crcOut),
    .o_err               (errOut),
    .o_byte_count        (byteCount)
  );

  // Reflected CRC-32 engine: processes bytes 0..n-1 where sel bit n-1 is set.
  function automatic logic [31:0] crcBeat(input logic [31:0] c, input logic [63:0] d,
                                          input logic [7:0] sel);
    logic [31:0] r;
    r = c;
    for (int j = 0; j < 8; j++) begin
      if ((sel >> j) != 8'h00) begin
        r = r ^ {24'h0, d[8*j +: 8]};
        for (int b = 0; b < 8; b++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      end
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (!rstN)            engQ <= 32'hFFFFFFFF;
    else if (loadStart)   engQ <= 32'hFFFFFFFF;
    else if (loadCascade) engQ <= crcBeat(engQ, dataOut, cascadeSel);
  end

  assign engCrc = ~engQ;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every rising o_crc_valid must match the oldest expected frame.
  always @(negedge clk) begin
    if (crcValid === 1'b1 && prevValid !== 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_result: got crc %0h with no frame pending", crcOut);
      end else begin
        monE = expQ.pop_front();
        checkOutput("result_crc", {32'h0, crcOut}, {32'h0, monE.crc});
        checkOutput("result_byte_count", {32'h0, byteCount}, {32'h0, monE.cnt});
        checkOutput("result_latency", $time - 5, monE.riseTime);
      end
    end
    prevValid = crcValid;
  end

  task automatic applyStimulus(input logic [63:0] d, input logic [3:0] nb, input logic last,
                               input logic abrt, input bit pushExp);
    int   waitCnt;
    logic [7:0] expSel;
    time  tAcc;
    waitCnt = 0;
    @(negedge clk);
    validIn = 1'b1;
    dataIn  = d;
    bytesIn = nb;
    lastIn  = last;
    abortIn = abrt;
    #1;
    while (readyOut !== 1'b1 && waitCnt < 20) begin
      @(negedge clk);
      #1;
      waitCnt++;
    end
    if (readyOut !== 1'b1) begin
      checks++;
      failures++;
      $display("[TB] FAIL ready_timeout: got ready %b expected 1", readyOut);
      validIn = 1'b0;
      return;
    end
    if (nb == 4'd0)     expSel = 8'h00;
    else if (nb > 4'd8) expSel = 8'h80;
    else                expSel = 8'h01 << (nb - 4'd1);
    checkOutput("load_from_cascade", {63'h0, loadCascade}, {63'h0, (!abrt && nb != 4'd0)});
    if (!abrt) begin
      checkOutput("cascade_sel", {56'h0, cascadeSel}, {56'h0, expSel});
      checkOutput("data_pass", dataOut, d);
    end
    @(posedge clk);
    tAcc = $time;
    if (pushExp) begin
      monE.crc      = CRC_CHECK;
      monE.cnt      = CNT9;
      monE.riseTime = tAcc + 30;
      expQ.push_back(monE);
    end
    #1;
    validIn = 1'b0;
    lastIn  = 1'b0;
    abortIn = 1'b0;
  endtask

  task automatic waitResult();
    int n;
    n = 0;
    @(negedge clk);
    while (crcValid !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (crcValid !== 1'b1) begin
      checks++;
      failures++;
      $display("[TB] FAIL result_timeout: got valid %b expected 1", crcValid);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("reset_ready", {63'h0, readyOut}, 64'h0);
    checkOutput("reset_crc_valid", {63'h0, crcValid}, 64'h0);
    checkOutput("reset_crc", {32'h0, crcOut}, 64'h0);
    checkOutput("reset_err", {63'h0, errOut}, 64'h0);
    checkOutput("reset_byte_count", {32'h0, byteCount}, 64'h0);
    checkOutput("reset_load_start", {63'h0, loadStart}, 64'h0);
    rstN = 1'b1;

    $display("[TB] scenario 1: clean 9-byte frame");
    applyStimulus(D8, 4'd8, 1'b0, 1'b0, 1'b0);
    applyStimulus(D9, 4'd1, 1'b1, 1'b0, 1'b1);
    waitResult();
    @(negedge clk);
    checkOutput("s1_valid_clear", {63'h0, crcValid}, 64'h0);

    $display("[TB] scenario 2: result held while ready is low");
    crcReadyIn = 1'b0;
    applyStimulus(D8, 4'd8, 1'b0, 1'b0, 1'b0);
    applyStimulus(D9, 4'd1, 1'b1, 1'b0, 1'b1);
    waitResult();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("s2_hold_valid", {63'h0, crcValid}, 64'h1);
      checkOutput("s2_hold_crc", {32'h0, crcOut}, {32'h0, CRC_CHECK});
    end
    crcReadyIn = 1'b1;
    @(negedge clk);
    checkOutput("s2_valid_clear", {63'h0, crcValid}, 64'h0);

    $display("[TB] scenario 3: abort with last beat, then clean frame");
    applyStimulus(D8, 4'd8, 1'b0, 1'b0, 1'b0);
    applyStimulus(D9, 4'd1, 1'b1, 1'b1, 1'b0);
    repeat (6) @(negedge clk);
    checkOutput("s3_no_result", {63'h0, crcValid}, 64'h0);
    checkOutput("s3_idle_ready", {63'h0, readyOut}, 64'h0);
    applyStimulus(D8, 4'd8, 1'b0, 1'b0, 1'b0);
    applyStimulus(D9, 4'd1, 1'b1, 1'b0, 1'b1);
    waitResult();
    @(negedge clk);

    $display("[TB] scenario 4: oversized byte count");
    applyStimulus(D8, 4'd9, 1'b0, 1'b0, 1'b0);
    checkOutput("s4_err_set", {63'h0, errOut}, 64'h1);
    applyStimulus(D9, 4'd1, 1'b1, 1'b0, 1'b1);
    waitResult();
    checkOutput("s4_err_sticky", {63'h0, errOut}, 64'h1);
    @(negedge clk);

    $display("[TB] scenario 5: zero-byte last beat");
    applyStimulus(D8, 4'd8, 1'b0, 1'b0, 1'b0);
    checkOutput("s5_err_cleared", {63'h0, errOut}, 64'h0);
    applyStimulus(D9, 4'd1, 1'b0, 1'b0, 1'b0);
    applyStimulus(64'h0, 4'd0, 1'b1, 1'b0, 1'b1);
    waitResult();
    @(negedge clk);

    $display("[TB] scenario 6: reset during DATA");
    applyStimulus(D8, 4'd8, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rstN = 1'b0;
    @(negedge clk);
    checkOutput("s6_ready", {63'h0, readyOut}, 64'h0);
    checkOutput("s6_crc_valid", {63'h0, crcValid}, 64'h0);
    checkOutput("s6_byte_count", {32'h0, byteCount}, 64'h0);
    checkOutput("s6_load_start", {63'h0, loadStart}, 64'h0);
    rstN = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("s6_no_result", {63'h0, crcValid}, 64'h0);
    checkOutput("queue_empty", 64'(expQ.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
